// File: rtl/dsi_seq_pkg.sv
// -----------------------------------------------------------------------------
// dsi_seq_pkg
// Shared definitions for the DSI high-speed burst sequencer:
//   CNT_W             - width of the cycle counters (clock pre/post, LP gap)
//   FILL_BYTE_DEFAULT - byte placed on the data lanes when nothing is streamed
//   seq_state_e       - sequencer states
//   gap_target()      - where a burst ends up once the clock lane is settled
// -----------------------------------------------------------------------------
package dsi_seq_pkg;

   localparam int         CNT_W             = 8;
   localparam logic [7:0] FILL_BYTE_DEFAULT = 8'h00;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CLK_GO,
      ST_CLK_PRE,
      ST_DATA_GO,
      ST_STREAM,
      ST_DATA_TRAIL,
      ST_CLK_POST,
      ST_CLK_TRAIL,
      ST_LP_GAP
   } seq_state_e;

   // A zero LP gap means the state is skipped outright rather than held for
   // one cycle.
   function automatic seq_state_e gap_target(input logic [CNT_W-1:0] gap);
      return (gap == '0) ? ST_IDLE : ST_LP_GAP;
   endfunction

endpackage

// File: rtl/dsi_seq_timer.sv
// -----------------------------------------------------------------------------
// dsi_seq_timer
// Loadable down-counter shared by the timed sequencer states.
//   clk_sys  in  clock
//   rst      in  synchronous active-high reset
//   load     in  load load_val this cycle (state entry)
//   load_val in  cycle count; the state lasts exactly this many cycles
//   done     out high in the last cycle of the count
// The counter stops at zero and never wraps.
// -----------------------------------------------------------------------------
module dsi_seq_timer
   import dsi_seq_pkg::*;
(
   input  logic             clk_sys,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // The count loaded at entry is seen in the first cycle of the state, so
   // the final cycle is the one where the count reads 1 (or 0 if idle).
   assign done = (count_q[CNT_W-1:1] == '0);

endmodule

// File: rtl/dsi_hs_sequencer.sv
// -----------------------------------------------------------------------------
// dsi_hs_sequencer
// Sequences one DSI high-speed burst: brings up the clock lane, waits the
// clock-pre time, starts the data lanes, streams the packet, collects lane
// end-of-transmission acks, waits clock-post, releases the clock lane (unless
// it runs continuously) and enforces a minimum LP gap before the next burst.
// Ports:
//   clk_sys, rst                        clock, synchronous active-high reset
//   cfg_clk_continuous                  keep clock lane in HS between bursts
//   cfg_clk_pre/post, cfg_lp_gap        cycle counts, sampled at state entry
//   s_tdata/s_tvalid/s_tlast/s_tready   packet stream, byte i -> lane i
//   clk_lane_*                          clock-lane request/status
//   dat_lane_start/fin_rqst, dat_lane_data   broadcast to all data lanes
//   dat_lane_data_rqst/active/fin_ack   per-lane status
//   busy, err_underflow, err_clr        status, sticky underflow flag + clear
// -----------------------------------------------------------------------------
module dsi_hs_sequencer
   import dsi_seq_pkg::*;
#(
   parameter int         LANES     = 4,
   parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
   input  logic                 clk_sys,
   input  logic                 rst,
   input  logic                 cfg_clk_continuous,
   input  logic [7:0]           cfg_clk_pre,
   input  logic [7:0]           cfg_clk_post,
   input  logic [7:0]           cfg_lp_gap,
   input  logic [8*LANES-1:0]   s_tdata,
   input  logic                 s_tvalid,
   input  logic                 s_tlast,
   output logic                 s_tready,
   output logic                 clk_lane_start_rqst,
   output logic                 clk_lane_fin_rqst,
   input  logic                 clk_lane_active,
   input  logic                 clk_lane_fin_ack,
   output logic                 dat_lane_start_rqst,
   output logic                 dat_lane_fin_rqst,
   output logic [8*LANES-1:0]   dat_lane_data,
   input  logic [LANES-1:0]     dat_lane_data_rqst,
   input  logic [LANES-1:0]     dat_lane_active,
   input  logic [LANES-1:0]     dat_lane_fin_ack,
   output logic                 busy,
   output logic                 err_underflow,
   input  logic                 err_clr
);

   localparam logic [8*LANES-1:0] FILL_WORD = {LANES{FILL_BYTE}};

   seq_state_e          state_q, state_d;
   logic [LANES-1:0]    ack_mask_q, ack_mask_d;
   logic [8*LANES-1:0]  data_q, data_d;
   logic                cstart_q, cstart_d;
   logic                cfin_q, cfin_d;
   logic                dstart_q, dstart_d;
   logic                dfin_q, dfin_d;
   logic                err_q, err_d;

   logic                entering;
   logic [CNT_W-1:0]    tmr_val;
   logic                tmr_done;
   logic                lanes_rdy, beat, underflow, acks_done;
   seq_state_e          pre_tgt, post_exit_tgt;

   // Lane HS status is carried on the interface for the PHY wrapper; the
   // sequencing itself is driven purely by data_rqst and fin_ack.
   logic                unused_lane_active;
   assign unused_lane_active = ^dat_lane_active;

   assign lanes_rdy = &dat_lane_data_rqst;
   // The handshake that carries s_tlast moves the FSM out of STREAM, so
   // s_tready drops automatically once the last word is taken.
   assign s_tready  = (state_q == ST_STREAM) && lanes_rdy;
   assign beat      = s_tready && s_tvalid;
   assign underflow = s_tready && !s_tvalid;
   // Include this cycle's acks so the final ack ends DATA_TRAIL immediately.
   assign acks_done = &(ack_mask_q | dat_lane_fin_ack);

   // A zero pre/post count skips its state instead of spending one cycle in it.
   assign pre_tgt       = (cfg_clk_pre == '0) ? ST_DATA_GO : ST_CLK_PRE;
   assign post_exit_tgt = cfg_clk_continuous ? gap_target(cfg_lp_gap) : ST_CLK_TRAIL;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (s_tvalid) begin
               state_d = clk_lane_active ? pre_tgt : ST_CLK_GO;
            end else if (!cfg_clk_continuous && clk_lane_active) begin
               // Continuous mode was switched off with the clock still running.
               state_d = ST_CLK_TRAIL;
            end
         end
         ST_CLK_GO:     if (clk_lane_active)  state_d = pre_tgt;
         ST_CLK_PRE:    if (tmr_done)         state_d = ST_DATA_GO;
         ST_DATA_GO:    if (lanes_rdy)        state_d = ST_STREAM;
         ST_STREAM:     if (beat && s_tlast)  state_d = ST_DATA_TRAIL;
         ST_DATA_TRAIL: begin
            if (acks_done) begin
               state_d = (cfg_clk_post == '0) ? post_exit_tgt : ST_CLK_POST;
            end
         end
         ST_CLK_POST:   if (tmr_done)         state_d = post_exit_tgt;
         ST_CLK_TRAIL:  if (clk_lane_fin_ack) state_d = gap_target(cfg_lp_gap);
         ST_LP_GAP:     if (tmr_done)         state_d = ST_IDLE;
         default:                             state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      entering = (state_d != state_q);
      tmr_val  = '0;
      case (state_d)
         ST_CLK_PRE:  tmr_val = cfg_clk_pre;
         ST_CLK_POST: tmr_val = cfg_clk_post;
         ST_LP_GAP:   tmr_val = cfg_lp_gap;
         default:     tmr_val = '0;
      endcase

      // Request pulses are registered so they coincide with the first cycle
      // spent in the state they belong to.
      cstart_d = entering && (state_d == ST_CLK_GO);
      dstart_d = entering && (state_d == ST_DATA_GO);
      cfin_d   = entering && (state_d == ST_CLK_TRAIL);
      dfin_d   = beat && s_tlast;

      data_d = FILL_WORD;
      if (beat) begin
         data_d = s_tdata;
      end

      ack_mask_d = '0;
      if ((state_q == ST_DATA_TRAIL) && (state_d == ST_DATA_TRAIL)) begin
         ack_mask_d = ack_mask_q | dat_lane_fin_ack;
      end

      // A new underflow wins over a simultaneous clear.
      err_d = underflow || (err_q && !err_clr);
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ack_mask_q <= '0;
         data_q     <= FILL_WORD;
         cstart_q   <= 1'b0;
         cfin_q     <= 1'b0;
         dstart_q   <= 1'b0;
         dfin_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ack_mask_q <= ack_mask_d;
         data_q     <= data_d;
         cstart_q   <= cstart_d;
         cfin_q     <= cfin_d;
         dstart_q   <= dstart_d;
         dfin_q     <= dfin_d;
         err_q      <= err_d;
      end
   end

   dsi_seq_timer u_timer (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .load     (entering),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   assign clk_lane_start_rqst = cstart_q;
   assign clk_lane_fin_rqst   = cfin_q;
   assign dat_lane_start_rqst = dstart_q;
   assign dat_lane_fin_rqst   = dfin_q;
   assign dat_lane_data       = data_q;
   assign err_underflow       = err_q;
   assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dsi_hs_sequencer.sv
module tb_dsi_hs_sequencer;

   localparam int LANES = 4;

   logic                clk_sys = 1'b0;
   logic                rst;
   logic                cfg_clk_continuous;
   logic [7:0]          cfg_clk_pre, cfg_clk_post, cfg_lp_gap;
   logic [8*LANES-1:0]  s_tdata;
   logic                s_tvalid, s_tlast, s_tready;
   logic                clk_lane_start_rqst, clk_lane_fin_rqst;
   logic                clk_lane_active, clk_lane_fin_ack;
   logic                dat_lane_start_rqst, dat_lane_fin_rqst;
   logic [8*LANES-1:0]  dat_lane_data;
   logic [LANES-1:0]    dat_lane_data_rqst, dat_lane_active, dat_lane_fin_ack;
   logic                busy, err_underflow, err_clr;

   always #5 clk_sys = ~clk_sys;

   dsi_hs_sequencer #(.LANES(LANES), .FILL_BYTE(8'h00)) dut (
      .clk_sys             (clk_sys),
      .rst                 (rst),
      .cfg_clk_continuous  (cfg_clk_continuous),
      .cfg_clk_pre         (cfg_clk_pre),
      .cfg_clk_post        (cfg_clk_post),
      .cfg_lp_gap          (cfg_lp_gap),
      .s_tdata             (s_tdata),
      .s_tvalid            (s_tvalid),
      .s_tlast             (s_tlast),
      .s_tready            (s_tready),
      .clk_lane_start_rqst (clk_lane_start_rqst),
      .clk_lane_fin_rqst   (clk_lane_fin_rqst),
      .clk_lane_active     (clk_lane_active),
      .clk_lane_fin_ack    (clk_lane_fin_ack),
      .dat_lane_start_rqst (dat_lane_start_rqst),
      .dat_lane_fin_rqst   (dat_lane_fin_rqst),
      .dat_lane_data       (dat_lane_data),
      .dat_lane_data_rqst  (dat_lane_data_rqst),
      .dat_lane_active     (dat_lane_active),
      .dat_lane_fin_ack    (dat_lane_fin_ack),
      .busy                (busy),
      .err_underflow       (err_underflow),
      .err_clr             (err_clr)
   );

   // ---------------- lane model: one-cycle response, per-lane ack delay ----
   logic              clk_active_m, clk_ack_m;
   logic [LANES-1:0]  drqst_m, dack_m, pend_m;
   int                cnt_m [LANES];
   int                ack_dly [LANES];

   assign clk_lane_active    = clk_active_m;
   assign clk_lane_fin_ack   = clk_ack_m;
   assign dat_lane_data_rqst = drqst_m;
   assign dat_lane_active    = drqst_m;
   assign dat_lane_fin_ack   = dack_m;

   always @(posedge clk_sys) begin
      if (rst) begin
         clk_active_m <= 1'b0;
         clk_ack_m    <= 1'b0;
         drqst_m      <= '0;
         dack_m       <= '0;
         pend_m       <= '0;
      end else begin
         clk_ack_m <= 1'b0;
         if (clk_lane_start_rqst) clk_active_m <= 1'b1;
         if (clk_lane_fin_rqst) begin
            clk_active_m <= 1'b0;
            clk_ack_m    <= 1'b1;
         end
         if (dat_lane_start_rqst) drqst_m <= '1;
         for (int i = 0; i < LANES; i++) begin
            dack_m[i] <= 1'b0;
            if (dat_lane_fin_rqst) begin
               drqst_m[i] <= 1'b0;
               if (ack_dly[i] == 0) dack_m[i] <= 1'b1;
               else begin
                  cnt_m[i]  <= ack_dly[i];
                  pend_m[i] <= 1'b1;
               end
            end else if (pend_m[i]) begin
               if (cnt_m[i] == 1) begin
                  dack_m[i] <= 1'b1;
                  pend_m[i] <= 1'b0;
               end else begin
                  cnt_m[i] <= cnt_m[i] - 1;
               end
            end
         end
      end
   end

   // ---------------- event monitor (samples on falling edge) ---------------
   int           cyc = 0;
   int           n_cs = 0, n_cf = 0, n_ca = 0, n_ds = 0, n_fn = 0, n_id = 0, n_w = 0;
   int           t_cs [32], t_cf [32], t_ca [32], t_ds [32], t_fn [32], t_id [32];
   logic [31:0]  fin_word [32];
   logic [31:0]  words [256];
   logic         busy_prev = 1'b0, beat_prev = 1'b0;

   always @(negedge clk_sys) begin
      cyc = cyc + 1;
      if (clk_lane_start_rqst && n_cs < 32) begin t_cs[n_cs] = cyc; n_cs = n_cs + 1; end
      if (clk_lane_fin_rqst   && n_cf < 32) begin t_cf[n_cf] = cyc; n_cf = n_cf + 1; end
      if (clk_lane_fin_ack    && n_ca < 32) begin t_ca[n_ca] = cyc; n_ca = n_ca + 1; end
      if (dat_lane_start_rqst && n_ds < 32) begin t_ds[n_ds] = cyc; n_ds = n_ds + 1; end
      if (dat_lane_fin_rqst   && n_fn < 32) begin
         t_fn[n_fn] = cyc; fin_word[n_fn] = dat_lane_data; n_fn = n_fn + 1;
      end
      if (busy_prev && !busy && n_id < 32) begin t_id[n_id] = cyc; n_id = n_id + 1; end
      busy_prev = busy;
      // a word slot follows every cycle in which the sequencer was ready
      if (beat_prev && n_w < 256) begin words[n_w] = dat_lane_data; n_w = n_w + 1; end
      beat_prev = s_tready;
   end

   // ---------------- checking helpers ----------------
   int vectors = 0, miscompares = 0;
   int b_cs, b_cf, b_ca, b_ds, b_fn, b_id, b_w;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_cs = n_cs; b_cf = n_cf; b_ca = n_ca; b_ds = n_ds; b_fn = n_fn; b_id = n_id; b_w = n_w;
   endtask

   task automatic send_word(input string tag, input logic [31:0] w, input logic last);
      logic hs;
      int   n;
      hs = 1'b0;
      n  = 0;
      s_tvalid = 1'b1; s_tdata = w; s_tlast = last;
      while (!hs && n < 100) begin
         @(negedge clk_sys);
         hs = s_tready;
         @(posedge clk_sys); #1;
         n++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
      chk(tag, {31'b0, hs}, 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int base, n;
      base = n_id;
      n    = 0;
      while (n_id == base && n < 200) begin
         @(negedge clk_sys); #1;
         n++;
      end
      chk(tag, {31'b0, (n_id != base)}, 32'd1);
      @(posedge clk_sys); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cfg_clk_continuous = 1'b0;
      cfg_clk_pre = 8'd3; cfg_clk_post = 8'd2; cfg_lp_gap = 8'd4;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; err_clr = 1'b0;
      for (int i = 0; i < LANES; i++) ack_dly[i] = 0;

      // ---- reset state
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_tready", {31'b0, s_tready}, 32'd0);
      chk("rst_rqsts", {28'b0, clk_lane_start_rqst, clk_lane_fin_rqst,
                        dat_lane_start_rqst, dat_lane_fin_rqst}, 32'd0);
      chk("rst_data", dat_lane_data, 32'h0000_0000);
      chk("rst_err", {31'b0, err_underflow}, 32'd0);
      @(posedge clk_sys); #1;
      rst = 1'b0;
      @(posedge clk_sys); #1;

      // ---- 3-word burst, pre=3 post=2 gap=4, ideal lanes
      snap();
      send_word("s1_hs0", 32'h0302_0100, 1'b0);
      send_word("s1_hs1", 32'h1312_1110, 1'b0);
      send_word("s1_hs2", 32'h2322_2120, 1'b1);
      wait_idle("s1_idle");
      chk("s1_clk_start_cnt", n_cs - b_cs, 32'd1);
      // CLK_GO two cycles (lane answers after one) + three CLK_PRE cycles
      chk("s1_pre_to_dstart", t_ds[b_ds] - t_cs[b_cs], 32'd5);
      chk("s1_word_cnt", n_w - b_w, 32'd3);
      chk("s1_word0", words[b_w],     32'h0302_0100);
      chk("s1_word1", words[b_w + 1], 32'h1312_1110);
      chk("s1_word2", words[b_w + 2], 32'h2322_2120);
      chk("s1_fin_word", fin_word[b_fn], 32'h2322_2120);
      chk("s1_dstart_to_fin", t_fn[b_fn] - t_ds[b_ds], 32'd5);
      // two DATA_TRAIL cycles (acks next cycle) + two CLK_POST cycles
      chk("s1_fin_to_clkfin", t_cf[b_cf] - t_fn[b_fn], 32'd4);
      // ack cycle itself, then four LP_GAP cycles
      chk("s1_ack_to_idle", t_id[b_id] - t_ca[b_ca], 32'd5);
      chk("s1_err", {31'b0, err_underflow}, 32'd0);

      // ---- underflow: valid dropped two cycles, clear coincides with 2nd
      snap();
      send_word("s2_hs0", 32'hA3A2_A1A0, 1'b0);
      @(posedge clk_sys); #1;
      err_clr = 1'b1;
      @(posedge clk_sys); #1;
      err_clr = 1'b0;
      send_word("s2_hs1", 32'hB3B2_B1B0, 1'b0);
      send_word("s2_hs2", 32'hC3C2_C1C0, 1'b1);
      wait_idle("s2_idle");
      chk("s2_word_cnt", n_w - b_w, 32'd5);
      chk("s2_word0", words[b_w],     32'hA3A2_A1A0);
      chk("s2_fill0", words[b_w + 1], 32'h0000_0000);
      chk("s2_fill1", words[b_w + 2], 32'h0000_0000);
      chk("s2_word1", words[b_w + 3], 32'hB3B2_B1B0);
      chk("s2_word2", words[b_w + 4], 32'hC3C2_C1C0);
      chk("s2_err_set", {31'b0, err_underflow}, 32'd1);
      err_clr = 1'b1;
      @(posedge clk_sys); #1;
      err_clr = 1'b0;
      @(negedge clk_sys);
      chk("s2_err_clr", {31'b0, err_underflow}, 32'd0);
      @(posedge clk_sys); #1;

      // ---- staggered lane acks 0,1,5,2
      ack_dly[0] = 0; ack_dly[1] = 1; ack_dly[2] = 5; ack_dly[3] = 2;
      snap();
      send_word("s3_hs0", 32'h4444_4444, 1'b0);
      send_word("s3_hs1", 32'h5555_5555, 1'b1);
      wait_idle("s3_idle");
      // last ack 6 cycles after fin, then two CLK_POST cycles
      chk("s3_fin_to_clkfin", t_cf[b_cf] - t_fn[b_fn], 32'd9);
      chk("s3_fin_word", fin_word[b_fn], 32'h5555_5555);
      for (int i = 0; i < LANES; i++) ack_dly[i] = 0;

      // ---- continuous clock, two back-to-back packets
      cfg_clk_continuous = 1'b1;
      snap();
      send_word("s4_hsA0", 32'hAAAA_0000, 1'b0);
      send_word("s4_hsA1", 32'hAAAA_0001, 1'b1);
      send_word("s4_hsB0", 32'hBBBB_0000, 1'b0);
      send_word("s4_hsB1", 32'hBBBB_0001, 1'b1);
      wait_idle("s4_idle");
      chk("s4_clk_start_cnt", n_cs - b_cs, 32'd1);
      chk("s4_clk_fin_cnt", n_cf - b_cf, 32'd0);
      // DATA_TRAIL 2 + CLK_POST 2 + LP_GAP 4, B held off throughout
      chk("s4_fin_to_idle", t_id[b_id] - t_fn[b_fn], 32'd8);
      // IDLE goes straight to CLK_PRE (3 cycles) then DATA_GO
      chk("s4_idle_to_dstartB", t_ds[b_ds + 1] - t_id[b_id], 32'd4);
      chk("s4_word_cnt", n_w - b_w, 32'd4);
      chk("s4_wordA1", words[b_w + 1], 32'hAAAA_0001);
      chk("s4_wordB0", words[b_w + 2], 32'hBBBB_0000);
      // switching continuous mode off while idle releases the clock lane
      cfg_clk_continuous = 1'b0;
      wait_idle("s4_release_idle");
      chk("s4_release_fin_cnt", n_cf - b_cf, 32'd1);
      chk("s4_release_no_burst", n_ds - b_ds, 32'd2);
      chk("s4_release_gap", t_id[b_id + 2] - t_ca[b_ca], 32'd5);

      // ---- single word, all counts zero
      cfg_clk_pre = 8'd0; cfg_clk_post = 8'd0; cfg_lp_gap = 8'd0;
      snap();
      send_word("s5_hs0", 32'h7654_3210, 1'b1);
      wait_idle("s5_idle");
      chk("s5_cstart_to_dstart", t_ds[b_ds] - t_cs[b_cs], 32'd2);
      chk("s5_dstart_to_fin", t_fn[b_fn] - t_ds[b_ds], 32'd3);
      chk("s5_fin_word", fin_word[b_fn], 32'h7654_3210);
      chk("s5_word_cnt", n_w - b_w, 32'd1);
      chk("s5_fin_to_clkfin", t_cf[b_cf] - t_fn[b_fn], 32'd2);
      chk("s5_ack_to_idle", t_id[b_id] - t_ca[b_ca], 32'd1);

      // ---- reset in STREAM
      cfg_clk_pre = 8'd3; cfg_clk_post = 8'd2; cfg_lp_gap = 8'd4;
      send_word("s6_hs0", 32'h9999_8888, 1'b0);
      rst = 1'b1;
      @(posedge clk_sys); #1;
      @(negedge clk_sys);
      chk("s6_busy", {31'b0, busy}, 32'd0);
      chk("s6_tready", {31'b0, s_tready}, 32'd0);
      chk("s6_fins", {30'b0, dat_lane_fin_rqst, clk_lane_fin_rqst}, 32'd0);
      chk("s6_data", dat_lane_data, 32'h0000_0000);
      chk("s6_err", {31'b0, err_underflow}, 32'd0);
      snap();
      @(posedge clk_sys); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk_sys);
      @(negedge clk_sys);
      chk("s6_no_dat_fin", n_fn - b_fn, 32'd0);
      chk("s6_no_clk_fin", n_cf - b_cf, 32'd0);
      chk("s6_still_idle", {31'b0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
